mem_sched: RTL and testbench
============================

Name: mem_sched

Overview:
- Shares the single byte-wide RAM port between three 32-bit requesters: instruction fetch (if), load/store (ls) and an optional I-cache prefetcher (pf).
- Arbitrates between them, serializes each 1/2/4-byte access into byte cycles, and reassembles little-endian read data.
- Sits between the pipeline stages and the external rom_* pins.
- Drives a busy flag used for pipeline stall generation.

Parameters:
- STARVE_MAX, 8: consecutive arbitration losses of a pending if_req to ls, after which if wins the next arbitration.
- CW, 4: width of the starvation counter; must satisfy 2^CW > STARVE_MAX.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- if_req  in  1  fetch request, held until if_ok
- if_a  in  32  fetch address; always a 4-byte read
- if_ok  out  1  one-cycle pulse, fetch done
- if_n  out  32  fetch data, valid with if_ok
- ls_req  in  1  load/store request, held until ls_ok
- ls_wr  in  1  1=store, 0=load
- ls_a  in  32  load/store address
- ls_cu  in  2  size: 0=1 byte, 1=2 bytes, 2=4 bytes, 3=4 bytes
- ls_n_i  in  32  store data, low bytes first
- ls_n_o  out  32  load data, zero-extended, valid with ls_ok
- ls_ok  out  1  one-cycle pulse, load/store done
- pf_req  in  1  prefetch request
- pf_a  in  32  prefetch address; always a 4-byte read
- pf_ok  out  1  one-cycle pulse, prefetch done
- pf_n  out  32  prefetch data
- rom_rn  in  8  RAM read byte; returns the cycle after the address is presented
- rom_wn  out  8  RAM write byte
- rom_a  out  32  RAM byte address
- rom_wr  out  1  1=write this cycle
- busy  out  1  high in any non-IDLE state

Behaviour:
- Reset (async, any time, including mid-transfer):
  - State to IDLE; current access is dropped with no ok pulse.
  - All outputs 0; starvation counter 0; assembly register 0.
- States: IDLE, XFER, DONE.
- IDLE:
  - rom_a=0, rom_wr=0, rom_wn=0.
  - At the clock edge, grant in priority order: ls > if > pf.
  - Override: if the starvation counter equals STARVE_MAX and if_req is high, if wins over ls.
  - pf is granted only when if_req=0 and ls_req=0.
  - Granting latches the address, size (n=1/2/4), wr flag and owner, sets byte index k=0, and moves to XFER.
  - No request: stay in IDLE.
- Starvation counter:
  - Increments (saturating) on each grant to ls while if_req=1.
  - Clears on every grant to if, and whenever if_req=0 in IDLE.
- XFER, cycle k for k<n:
  - rom_a = latched_addr + k (32-bit wrap-around).
  - rom_wr = wr.
  - rom_wn = byte k of ls_n_i for writes, else 0.
- Read data capture:
  - rom_rn sampled in cycle k+1 is byte k, stored into bits [8k+7:8k].
  - Reads stay in XFER for n+1 cycles; in the final cycle rom_wr=0 and rom_a holds its last value.
  - Writes stay in XFER for n cycles.
- DONE:
  - Exactly one cycle.
  - The owner's ok=1 with assembled data; other ok outputs are 0.
  - Unused upper bytes are 0.
  - Requests are ignored in DONE; the next state is always IDLE.
- Data outputs if_n / ls_n_o / pf_n hold their value until the next DONE for the same port.
- Requester handshake:
  - A requester must drop req in the cycle it sees ok, unless it wants a new access.
  - A req still high when the block returns to IDLE starts a new access.
- Latency from grant edge to ok:
  - read: n+2 cycles (4-byte fetch: 6 cycles)
  - write: n+1 cycles
- Requester inputs are sampled only at grant; later changes to address or data are ignored.

Optional Feature:
- Macro MEM_SCHED_PF_EN.
- Defined: pf port behaves as above.
- Undefined:
  - pf_req and pf_a are ignored.
  - pf_ok=0 and pf_n=0 constantly.
  - Arbitration is ls > if with starvation override only.

Test Plan:
- Fetch: if_req with if_a=0x100, RAM returns 0x13,0x05,0x00,0x00 → rom_a steps 0x100..0x103; if_ok at grant+6; if_n=0x00000513.
- Store byte: ls_req, ls_wr=1, ls_cu=0, ls_a=0x30000, ls_n_i=0x41 → exactly one cycle with rom_wr=1, rom_a=0x30000, rom_wn=0x41; ls_ok at grant+2.
- Simultaneous: if_req, ls_req, pf_req all high in IDLE → ls granted first, then if, then pf; no overlap of ok pulses.
- Starvation: ls_req held continuously (re-asserting after each ok) with if_req pending and STARVE_MAX=8 → after 8 ls grants, if is granted; counter returns to 0.
- Reset mid-read: rst asserted in the 3rd XFER cycle of a fetch → outputs 0 immediately; no if_ok; busy=0; after release, a held if_req restarts at byte 0.
- Wrap: ls read, ls_cu=2, ls_a=0xFFFFFFFE → rom_a sequence 0xFFFFFFFE, 0xFFFFFFFF, 0x0, 0x1.

Source files
------------

// File: rtl/mem_sched.sv
// mem_sched: arbitrates if / ls / optional pf requesters onto one byte-wide RAM port.
// Latency: grant-cycle to ok is n+2 cycles for reads, n+1 for writes (n = 1/2/4 bytes).
// Backpressure: requesters hold req until their one-cycle ok pulse; busy is high outside IDLE.
//
// Ports:
//   clk, rst          - clock (rising edge), asynchronous active-high reset
//   if_req/if_a       - 4-byte fetch request; if_ok/if_n return the assembled word
//   ls_req/ls_wr/...  - load/store of 1/2/4 bytes (ls_cu); ls_ok/ls_n_o return load data
//   pf_req/pf_a       - 4-byte prefetch request; pf_ok/pf_n return the assembled word
//   rom_*             - external byte RAM: address, write strobe, write byte, read byte
//   busy              - high in any non-IDLE state, used for pipeline stalls
// Optional feature: define MEM_SCHED_PF_EN to enable the prefetch port; when undefined
// pf_req/pf_a are ignored and pf_ok/pf_n stay 0.
module mem_sched #(
  parameter int STARVE_MAX = 8,
  parameter int CW         = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_a,
  output logic        if_ok,
  output logic [31:0] if_n,
  input  logic        ls_req,
  input  logic        ls_wr,
  input  logic [31:0] ls_a,
  input  logic [1:0]  ls_cu,
  input  logic [31:0] ls_n_i,
  output logic [31:0] ls_n_o,
  output logic        ls_ok,
  input  logic        pf_req,
  input  logic [31:0] pf_a,
  output logic        pf_ok,
  output logic [31:0] pf_n,
  input  logic [7:0]  rom_rn,
  output logic [7:0]  rom_wn,
  output logic [31:0] rom_a,
  output logic        rom_wr,
  output logic        busy
);

  typedef enum logic [1:0] {S_IDLE, S_XFER, S_DONE} state_t;
  typedef enum logic [1:0] {OWN_IF, OWN_LS, OWN_PF} own_t;

  state_t        state_q, state_d;
  own_t          own_q, own_d;
  logic [31:0]   addr_q, addr_d;
  logic [2:0]    len_q, len_d;
  logic          wr_q, wr_d;
  logic [31:0]   wd_q, wd_d;
  logic [2:0]    k_q, k_d;
  logic [31:0]   asm_q, asm_d;
  logic [CW-1:0] starve_q, starve_d;
  logic [31:0]   rom_a_q, rom_a_d;
  logic          rom_wr_q, rom_wr_d;
  logic [7:0]    rom_wn_q, rom_wn_d;
  logic          if_ok_q, if_ok_d;
  logic          ls_ok_q, ls_ok_d;
  logic          pf_ok_q, pf_ok_d;
  logic [31:0]   if_n_q, if_n_d;
  logic [31:0]   ls_n_q, ls_n_d;
  logic [31:0]   pf_n_q, pf_n_d;
  logic          busy_q, busy_d;

  logic       gnt_ls, gnt_if, gnt_pf;
  logic       starved;
  logic [2:0] ls_len;
  logic [2:0] k_nxt;
  logic [1:0] cap_idx;
  logic       last;

  // Starvation override: a pending fetch that has lost STARVE_MAX times beats ls.
  assign starved = if_req && (starve_q == CW'(STARVE_MAX));
  assign gnt_ls  = ls_req && !starved;
  assign gnt_if  = if_req && !gnt_ls;

`ifdef MEM_SCHED_PF_EN
  assign gnt_pf = pf_req && !if_req && !ls_req;
`else
  assign gnt_pf = 1'b0;
  logic unused_pf;
  assign unused_pf = ^{pf_req, pf_a};
`endif

  // ls_cu = 3 is treated as a 4-byte access.
  assign ls_len = (ls_cu == 2'd0) ? 3'd1 : (ls_cu == 2'd1) ? 3'd2 : 3'd4;

  assign k_nxt   = k_q + 3'd1;
  // Read byte returned this cycle belongs to the address presented last cycle.
  assign cap_idx = k_q[1:0] - 2'd1;
  // Writes finish after the last byte cycle; reads need one extra cycle to capture it.
  assign last    = wr_q ? (k_q == (len_q - 3'd1)) : (k_q == len_q);

  always_comb begin
    state_d  = state_q;
    own_d    = own_q;
    addr_d   = addr_q;
    len_d    = len_q;
    wr_d     = wr_q;
    wd_d     = wd_q;
    k_d      = k_q;
    asm_d    = asm_q;
    starve_d = starve_q;
    rom_a_d  = rom_a_q;
    rom_wr_d = rom_wr_q;
    rom_wn_d = rom_wn_q;
    if_ok_d  = 1'b0;
    ls_ok_d  = 1'b0;
    pf_ok_d  = 1'b0;
    if_n_d   = if_n_q;
    ls_n_d   = ls_n_q;
    pf_n_d   = pf_n_q;

    case (state_q)
      S_IDLE: begin
        rom_a_d  = 32'd0;
        rom_wr_d = 1'b0;
        rom_wn_d = 8'd0;
        if (!if_req) starve_d = '0;
        if (gnt_ls || gnt_if || gnt_pf) begin
          state_d = S_XFER;
          k_d     = 3'd0;
          asm_d   = 32'd0;
          if (gnt_ls) begin
            own_d  = OWN_LS;
            addr_d = ls_a;
            len_d  = ls_len;
            wr_d   = ls_wr;
            wd_d   = ls_n_i;
            if (if_req && (starve_q != CW'(STARVE_MAX))) starve_d = starve_q + 1'b1;
          end else if (gnt_if) begin
            own_d    = OWN_IF;
            addr_d   = if_a;
            len_d    = 3'd4;
            wr_d     = 1'b0;
            wd_d     = 32'd0;
            starve_d = '0;
          end else begin
            own_d  = OWN_PF;
            addr_d = pf_a;
            len_d  = 3'd4;
            wr_d   = 1'b0;
            wd_d   = 32'd0;
          end
          // Present byte 0 in the first XFER cycle.
          rom_a_d  = addr_d;
          rom_wr_d = wr_d;
          rom_wn_d = wr_d ? wd_d[7:0] : 8'd0;
        end
      end

      S_XFER: begin
        if (!wr_q && (k_q != 3'd0)) asm_d[{cap_idx, 3'b000} +: 8] = rom_rn;
        if (last) begin
          state_d  = S_DONE;
          rom_a_d  = 32'd0;
          rom_wr_d = 1'b0;
          rom_wn_d = 8'd0;
          case (own_q)
            OWN_IF: begin
              if_ok_d = 1'b1;
              if_n_d  = asm_d;
            end
            OWN_LS: begin
              ls_ok_d = 1'b1;
              ls_n_d  = asm_d;
            end
`ifdef MEM_SCHED_PF_EN
            OWN_PF: begin
              pf_ok_d = 1'b1;
              pf_n_d  = asm_d;
            end
`endif
            default: ;
          endcase
        end else begin
          k_d = k_nxt;
          if (k_nxt < len_q) begin
            rom_a_d  = addr_q + {29'd0, k_nxt};
            rom_wr_d = wr_q;
            rom_wn_d = wr_q ? wd_q[{k_nxt[1:0], 3'b000} +: 8] : 8'd0;
          end else begin
            // Read tail cycle: address holds, no write.
            rom_wr_d = 1'b0;
            rom_wn_d = 8'd0;
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      own_q    <= OWN_IF;
      addr_q   <= 32'd0;
      len_q    <= 3'd0;
      wr_q     <= 1'b0;
      wd_q     <= 32'd0;
      k_q      <= 3'd0;
      asm_q    <= 32'd0;
      starve_q <= '0;
      rom_a_q  <= 32'd0;
      rom_wr_q <= 1'b0;
      rom_wn_q <= 8'd0;
      if_ok_q  <= 1'b0;
      ls_ok_q  <= 1'b0;
      pf_ok_q  <= 1'b0;
      if_n_q   <= 32'd0;
      ls_n_q   <= 32'd0;
      pf_n_q   <= 32'd0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      own_q    <= own_d;
      addr_q   <= addr_d;
      len_q    <= len_d;
      wr_q     <= wr_d;
      wd_q     <= wd_d;
      k_q      <= k_d;
      asm_q    <= asm_d;
      starve_q <= starve_d;
      rom_a_q  <= rom_a_d;
      rom_wr_q <= rom_wr_d;
      rom_wn_q <= rom_wn_d;
      if_ok_q  <= if_ok_d;
      ls_ok_q  <= ls_ok_d;
      pf_ok_q  <= pf_ok_d;
      if_n_q   <= if_n_d;
      ls_n_q   <= ls_n_d;
      pf_n_q   <= pf_n_d;
      busy_q   <= busy_d;
    end
  end

  assign rom_a  = rom_a_q;
  assign rom_wr = rom_wr_q;
  assign rom_wn = rom_wn_q;
  assign if_ok  = if_ok_q;
  assign ls_ok  = ls_ok_q;
  assign pf_ok  = pf_ok_q;
  assign if_n   = if_n_q;
  assign ls_n_o = ls_n_q;
  assign pf_n   = pf_n_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_mem_sched.sv
// tb_mem_sched: directed bench for mem_sched with a byte RAM responder model.
// Latency: n/a (bench).
// Backpressure: n/a (bench).
module tb_mem_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_a;
  logic        if_ok;
  logic [31:0] if_n;
  logic        ls_req;
  logic        ls_wr;
  logic [31:0] ls_a;
  logic [1:0]  ls_cu;
  logic [31:0] ls_n_i;
  logic [31:0] ls_n_o;
  logic        ls_ok;
  logic        pf_req;
  logic [31:0] pf_a;
  logic        pf_ok;
  logic [31:0] pf_n;
  logic [7:0]  rom_rn;
  logic [7:0]  rom_wn;
  logic [31:0] rom_a;
  logic        rom_wr;
  logic        busy;

  int n_chk  = 0;
  int n_pass = 0;

  logic [31:0] a_log  [0:31];
  logic        wr_log [0:31];
  logic [7:0]  wn_log [0:31];
  logic        bz_log [0:31];

  always #5 clk = ~clk;

  mem_sched #(.STARVE_MAX(8), .CW(4)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_a(if_a), .if_ok(if_ok), .if_n(if_n),
    .ls_req(ls_req), .ls_wr(ls_wr), .ls_a(ls_a), .ls_cu(ls_cu),
    .ls_n_i(ls_n_i), .ls_n_o(ls_n_o), .ls_ok(ls_ok),
    .pf_req(pf_req), .pf_a(pf_a), .pf_ok(pf_ok), .pf_n(pf_n),
    .rom_rn(rom_rn), .rom_wn(rom_wn), .rom_a(rom_a), .rom_wr(rom_wr),
    .busy(busy)
  );

  // RAM contents: a few fixed bytes, otherwise low address byte xor 0xA5.
  function automatic logic [7:0] ram_byte(input logic [31:0] a);
    case (a)
      32'h0000_0100: ram_byte = 8'h13;
      32'h0000_0101: ram_byte = 8'h05;
      32'h0000_0102: ram_byte = 8'h00;
      32'h0000_0103: ram_byte = 8'h00;
      32'hFFFF_FFFE: ram_byte = 8'h11;
      32'hFFFF_FFFF: ram_byte = 8'h22;
      32'h0000_0000: ram_byte = 8'h33;
      32'h0000_0001: ram_byte = 8'h44;
      default:       ram_byte = a[7:0] ^ 8'hA5;
    endcase
  endfunction

  // Read data arrives the cycle after the address.
  always @(posedge clk) rom_rn <= ram_byte(rom_a);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
  endtask

  // Waits (bounded) for the ok of port 0=if, 1=ls, 2=pf; lat=0 means it never came.
  task automatic wait_ok(input int port, input int max, output int lat);
    int c;
    c   = 0;
    lat = 0;
    while (lat == 0 && c < max) begin
      c++;
      @(negedge clk);
      a_log[c]  = rom_a;
      wr_log[c] = rom_wr;
      wn_log[c] = rom_wn;
      bz_log[c] = busy;
      if ((port == 0 && if_ok) || (port == 1 && ls_ok) || (port == 2 && pf_ok)) lat = c;
    end
  endtask

  initial begin
    int lat;
    int nwr;
    int ord [0:3];
    int n_ord;
    int overlap;
    int n_ls, n_if, r1, r2;
    logic saw_ok;

    rst = 1'b1;
    if_req = 1'b0; if_a = 32'd0;
    ls_req = 1'b0; ls_wr = 1'b0; ls_a = 32'd0; ls_cu = 2'd0; ls_n_i = 32'd0;
    pf_req = 1'b0; pf_a = 32'd0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_flags", {27'd0, if_ok, ls_ok, pf_ok, rom_wr, busy}, 32'd0);
    chk("rst_rom_a", rom_a, 32'd0);
    chk("rst_rom_wn", {24'd0, rom_wn}, 32'd0);
    chk("rst_data", if_n | ls_n_o | pf_n, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Fetch of 0x100
    if_req = 1'b1; if_a = 32'h100;
    wait_ok(0, 12, lat);
    if_req = 1'b0;
    chk("fetch_lat", lat, 6);
    for (int i = 1; i <= 4; i++) chk("fetch_rom_a", a_log[i], 32'h100 + i - 1);
    chk("fetch_tail_a", a_log[5], 32'h103);
    chk("fetch_tail_wr", {31'd0, wr_log[5]}, 32'd0);
    chk("fetch_busy", {31'd0, bz_log[1]}, 32'd1);
    chk("fetch_data", if_n, 32'h0000_0513);
    @(negedge clk);
    chk("fetch_ok_pulse", {30'd0, if_ok, busy}, 32'd0);

    // Store byte
    ls_req = 1'b1; ls_wr = 1'b1; ls_cu = 2'd0; ls_a = 32'h30000; ls_n_i = 32'h41;
    wait_ok(1, 12, lat);
    ls_req = 1'b0;
    chk("stb_lat", lat, 2);
    nwr = 0;
    for (int i = 1; i <= 12; i++) if (i <= lat && wr_log[i]) nwr++;
    chk("stb_nwr", nwr, 1);
    chk("stb_rom_a", a_log[1], 32'h30000);
    chk("stb_rom_wn", {24'd0, wn_log[1]}, 32'h41);
    chk("if_n_hold", if_n, 32'h0000_0513);
    @(negedge clk);

    // Store halfword: bytes DD, CC at 0x200, 0x201
    ls_req = 1'b1; ls_wr = 1'b1; ls_cu = 2'd1; ls_a = 32'h200; ls_n_i = 32'hAABB_CCDD;
    wait_ok(1, 12, lat);
    ls_req = 1'b0;
    chk("sth_lat", lat, 3);
    chk("sth_b0", {wr_log[1], 7'd0, wn_log[1], a_log[1][15:0]}, {1'b1, 7'd0, 8'hDD, 16'h0200});
    chk("sth_b1", {wr_log[2], 7'd0, wn_log[2], a_log[2][15:0]}, {1'b1, 7'd0, 8'hCC, 16'h0201});
    @(negedge clk);

    // Load byte at 0x30001: 0x01 ^ 0xA5, upper bytes zero
    ls_req = 1'b1; ls_wr = 1'b0; ls_cu = 2'd0; ls_a = 32'h30001;
    wait_ok(1, 12, lat);
    ls_req = 1'b0;
    chk("ldb_lat", lat, 3);
    chk("ldb_data", ls_n_o, 32'h0000_00A4);
    @(negedge clk);

    // Load halfword at 0x100
    ls_req = 1'b1; ls_wr = 1'b0; ls_cu = 2'd1; ls_a = 32'h100;
    wait_ok(1, 12, lat);
    ls_req = 1'b0;
    chk("ldh_lat", lat, 4);
    chk("ldh_data", ls_n_o, 32'h0000_0513);
    @(negedge clk);

    // Wrap-around word load (ls_cu=3 also means 4 bytes)
    ls_req = 1'b1; ls_wr = 1'b0; ls_cu = 2'd3; ls_a = 32'hFFFF_FFFE;
    wait_ok(1, 12, lat);
    ls_req = 1'b0;
    chk("wrap_lat", lat, 6);
    chk("wrap_a0", a_log[1], 32'hFFFF_FFFE);
    chk("wrap_a1", a_log[2], 32'hFFFF_FFFF);
    chk("wrap_a2", a_log[3], 32'h0000_0000);
    chk("wrap_a3", a_log[4], 32'h0000_0001);
    chk("wrap_data", ls_n_o, 32'h4433_2211);
    @(negedge clk);

    // Simultaneous requests
    if_req = 1'b1; if_a = 32'h100;
    ls_req = 1'b1; ls_wr = 1'b0; ls_cu = 2'd2; ls_a = 32'h200;
    pf_req = 1'b1; pf_a = 32'hFFFF_FFFE;
    n_ord = 0; overlap = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if ((int'(if_ok) + int'(ls_ok) + int'(pf_ok)) > 1) overlap++;
      if (ls_ok) begin if (n_ord < 4) ord[n_ord] = 1; n_ord++; ls_req = 1'b0; end
      if (if_ok) begin if (n_ord < 4) ord[n_ord] = 0; n_ord++; if_req = 1'b0; end
      if (pf_ok) begin if (n_ord < 4) ord[n_ord] = 2; n_ord++; pf_req = 1'b0; end
    end
    pf_req = 1'b0;
    chk("sim_overlap", overlap, 0);
    chk("sim_first_ls", ord[0], 1);
    chk("sim_second_if", ord[1], 0);
    chk("sim_ls_data", ls_n_o, 32'hA6A7_A4A5);
`ifdef MEM_SCHED_PF_EN
    chk("sim_count", n_ord, 3);
    chk("sim_third_pf", ord[2], 2);
    chk("sim_pf_data", pf_n, 32'h4433_2211);
`else
    chk("sim_count", n_ord, 2);
    chk("pf_off_data", pf_n, 32'd0);
`endif
    @(negedge clk);

    // Starvation: ls held, if pending; 8 ls grants, then if, twice
    ls_wr = 1'b1; ls_cu = 2'd0; ls_a = 32'h400; ls_n_i = 32'h5A; if_a = 32'h100;
    if_req = 1'b1; ls_req = 1'b1;
    n_ls = 0; n_if = 0; r1 = -1; r2 = -1;
    for (int c = 0; c < 200 && n_if < 2; c++) begin
      @(negedge clk);
      if (ls_ok) n_ls++;
      if (if_ok) begin
        if (n_if == 0) r1 = n_ls; else r2 = n_ls;
        n_ls = 0;
        n_if++;
        if (n_if == 2) begin if_req = 1'b0; ls_req = 1'b0; end
      end
    end
    if_req = 1'b0; ls_req = 1'b0;
    chk("starve_if_count", n_if, 2);
    chk("starve_round1", r1, 8);
    chk("starve_round2", r2, 8);
    @(negedge clk);

    // Reset in the 3rd XFER cycle of a fetch
    if_req = 1'b1; if_a = 32'h100;
    repeat (3) @(negedge clk);
    chk("rmid_pre_a", rom_a, 32'h102);
    rst = 1'b1;
    #1;
    chk("rmid_flags", {29'd0, if_ok, rom_wr, busy}, 32'd0);
    chk("rmid_rom_a", rom_a, 32'd0);
    chk("rmid_if_n", if_n, 32'd0);
    saw_ok = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (if_ok) saw_ok = 1'b1;
      if (c == 2) rst = 1'b0;
    end
    chk("rmid_no_ok", {31'd0, saw_ok}, 32'd0);
    // The held request restarted after release; wait for its completion from byte 0.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    wait_ok(0, 12, lat);
    if_req = 1'b0;
    chk("rmid_restart_lat", lat, 6);
    chk("rmid_restart_a0", a_log[1], 32'h100);
    chk("rmid_restart_data", if_n, 32'h0000_0513);
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
